io_bridge: RTL and testbench

- Sits directly downstream of the CPU top's byte-wide memory bus (address, data-out, data-in, write strobe) and drives the CPU's ready input.
- Decodes each access to either the 128 KB RAM or the memory-mapped I/O window (addr[17:16]==2'b11).
- Implements the I/O side: UART TX and RX byte FIFOs, a free-running clock counter and the program-stop latch.
- Returns read data with the CPU's 2-cycle read timing and stalls the CPU through ready when TX backpressure or halt requires it.

---
 rtl/io_bridge.sv | 94 +++++++++
 tb/tb_io_bridge.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/io_bridge.sv
// io_bridge: CPU byte-bus decode to RAM or I/O window (UART FIFOs, cycle counter, halt) with ready stalls.
module io_bridge #(
  parameter int TX_AW  = 4,
  parameter int RX_AW  = 4,
  parameter int RAM_AW = 17
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [31:0]       cpu_a,
  input  logic [7:0]        cpu_dout,
  input  logic              cpu_wr,
  output logic [7:0]        cpu_din,
  output logic              cpu_rdy,
  output logic [RAM_AW-1:0] ram_a,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  input  logic [7:0]        ram_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              halt
);
  logic              run_q, halt_q, src_q;
  logic [31:0]       cnt_q, snap_q;
  logic [7:0]        rd_q, rd_d, tx_wd;
  logic [7:0]        tx_mem [2**TX_AW];
  logic [7:0]        rx_mem [2**RX_AW];
  logic [TX_AW:0]    txw_q, txr_q;
  logic [RX_AW:0]    rxw_q, rxr_q;
  logic              io, a_tx, a_clk, tx_full, tx_empty, rx_full, rx_empty;
  logic              tx_push, tx_pop, rx_push, rx_pop, rd_acc;
  logic              unused_hi;
  assign unused_hi = ^cpu_a[31:18];
  always_comb begin
    io       = cpu_a[17:16] == 2'b11;
    a_tx     = cpu_a[17:0] == 18'h30000;
    a_clk    = cpu_a[17:0] == 18'h30004;
    tx_empty = txw_q == txr_q;
    tx_full  = (txw_q[TX_AW] != txr_q[TX_AW]) && (txw_q[TX_AW-1:0] == txr_q[TX_AW-1:0]);
    rx_empty = rxw_q == rxr_q;
    rx_full  = (rxw_q[RX_AW] != rxr_q[RX_AW]) && (rxw_q[RX_AW-1:0] == rxr_q[RX_AW-1:0]);
    cpu_rdy  = run_q && !halt_q && !(io && cpu_wr && (a_tx || a_clk) && tx_full);
    ram_a     = cpu_a[RAM_AW-1:0];
    ram_wdata = cpu_dout;
    ram_we    = !io && cpu_wr && cpu_rdy;
    tx_valid = !tx_empty;
    tx_data  = tx_mem[txr_q[TX_AW-1:0]];
    tx_pop   = tx_valid && tx_ready;
    tx_push  = cpu_rdy && io && cpu_wr && ((a_tx && cpu_dout != 8'h00) || a_clk);
    tx_wd    = a_clk ? 8'h00 : cpu_dout;
    rx_ready = run_q && !rx_full;
    rx_push  = rx_valid && rx_ready;
    rd_acc   = cpu_rdy && !cpu_wr;
    rx_pop   = rd_acc && io && a_tx && !rx_empty;
    // 0x30005..7 share the 0x30004 word; the low address bits pick the snapshot byte
    rd_d = a_tx ? (rx_empty ? 8'h00 : rx_mem[rxr_q[RX_AW-1:0]]) :
           a_clk ? cnt_q[7:0] :
           (cpu_a[17:2] == 16'hC001) ? snap_q[{cpu_a[1:0], 3'b000} +: 8] : 8'h00;
    cpu_din = src_q ? rd_q : (run_q ? ram_rdata : 8'h00);
    halt    = halt_q;
  end
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      run_q  <= 1'b0;
      halt_q <= 1'b0;
      src_q  <= 1'b0;
      cnt_q  <= '0;
      snap_q <= '0;
      rd_q   <= '0;
      txw_q  <= '0;
      txr_q  <= '0;
      rxw_q  <= '0;
      rxr_q  <= '0;
    end else begin
      run_q <= 1'b1;
      cnt_q <= cnt_q + 32'd1;
      if (cpu_rdy && io && cpu_wr && a_clk) halt_q <= 1'b1;
      if (rd_acc) src_q <= io;
      if (rd_acc && io) rd_q <= rd_d;
      if (rd_acc && io && a_clk) snap_q <= cnt_q;
      if (tx_push) txw_q <= txw_q + (TX_AW+1)'(1);
      if (tx_pop) txr_q <= txr_q + (TX_AW+1)'(1);
      if (rx_push) rxw_q <= rxw_q + (RX_AW+1)'(1);
      if (rx_pop) rxr_q <= rxr_q + (RX_AW+1)'(1);
    end
  end
  always_ff @(posedge clk_in) begin
    if (tx_push) tx_mem[txw_q[TX_AW-1:0]] <= tx_wd;
    if (rx_push) rx_mem[rxw_q[RX_AW-1:0]] <= rx_data;
  end
endmodule

// File: tb/tb_io_bridge.sv
// tb_io_bridge: directed vector table, hand sequences and random traffic against a queue-based model.
module tb_io_bridge;
  logic        clk_in = 1'b0, rst_in = 1'b0;
  logic [31:0] cpu_a = '0;
  logic [7:0]  cpu_dout = '0, rx_data = '0, ram_rdata = '0;
  logic        cpu_wr = 1'b0, tx_ready = 1'b0, rx_valid = 1'b0;
  logic [7:0]  cpu_din, tx_data, ram_wdata;
  logic [16:0] ram_a;
  logic        cpu_rdy, ram_we, tx_valid, rx_ready, halt;

  io_bridge dut (
    .clk_in(clk_in), .rst_in(rst_in), .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_wr(cpu_wr),
    .cpu_din(cpu_din), .cpu_rdy(cpu_rdy), .ram_a(ram_a), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .halt(halt)
  );

  always #5 clk_in = ~clk_in;

  // external synchronous RAM, read-before-write
  logic [7:0] mem [0:131071];
  always @(posedge clk_in) begin
    if (ram_we) mem[ram_a] <= ram_wdata;
    ram_rdata <= mem[ram_a];
  end

  int checks = 0, errors = 0;
  logic [7:0]  txq[$], rxq[$];
  logic [7:0]  mm [0:131071];
  logic [31:0] mcnt = '0, msnap = '0;
  logic        mhalt = 1'b0, mrun = 1'b0, msrc = 1'b0, mr_last = 1'b0;
  logic [7:0]  mrd = '0, mprev = '0;
  logic        s_rdy, s_txv, s_halt;
  logic [7:0]  s_din, s_txd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic [31:0] a, input logic [7:0] d, input logic wr,
                      input logic txr, input logic rxv, input logic [7:0] rxd);
    logic io, atx, aclk, mr, rxr;
    logic [7:0] v, din_e;
    logic [31:0] t;
    rst_in = rst; cpu_a = a; cpu_dout = d; cpu_wr = wr; tx_ready = txr; rx_valid = rxv; rx_data = rxd;
    if (!rst) begin
      txq.delete(); rxq.delete();
      mcnt = '0; msnap = '0; mhalt = 1'b0; mrun = 1'b0; msrc = 1'b0; mrd = '0;
    end
    @(negedge clk_in);
    io   = a[17:16] == 2'b11;
    atx  = a[17:0] == 18'h30000;
    aclk = a[17:0] == 18'h30004;
    mr   = mrun && !mhalt && !(io && wr && (atx || aclk) && txq.size() == 16);
    rxr  = mrun && rxq.size() < 16;
    din_e = !mrun ? 8'h00 : (msrc ? mrd : mprev);
    s_rdy = cpu_rdy; s_din = cpu_din; s_txv = tx_valid; s_txd = tx_data; s_halt = halt;
    chk("cpu_rdy", cpu_rdy, mr);
    chk("cpu_din", cpu_din, din_e);
    chk("tx_valid", tx_valid, txq.size() != 0);
    if (txq.size() != 0) chk("tx_data", tx_data, txq[0]);
    chk("rx_ready", rx_ready, rxr);
    chk("ram_we", ram_we, !io && wr && mr);
    if (!io) chk("ram_a", ram_a, a[16:0]);
    if (!io && wr) chk("ram_wdata", ram_wdata, d);
    chk("halt", halt, mhalt);
    mr_last = mr;
    v = mm[a[16:0]];
    if (rst) begin
      if (!io && wr && mr) mm[a[16:0]] = d;
      if (txq.size() != 0 && txr) void'(txq.pop_front());
      if (mr && !wr) begin
        msrc = io;
        if (io) begin
          if (atx) mrd = (rxq.size() != 0) ? rxq.pop_front() : 8'h00;
          else if (aclk) begin msnap = mcnt; mrd = mcnt[7:0]; end
          else if (a[17:0] >= 18'h30005 && a[17:0] <= 18'h30007) begin
            t = msnap >> (8 * (int'(a[17:0]) - 'h30004));
            mrd = t[7:0];
          end else mrd = 8'h00;
        end
      end
      if (rxv && rxr) rxq.push_back(rxd);
      if (mr && io && wr && atx && d != 8'h00) txq.push_back(d);
      if (mr && io && wr && aclk) begin txq.push_back(8'h00); mhalt = 1'b1; end
      mrun = 1'b1;
      mcnt = mcnt + 1;
    end
    mprev = v;
    @(posedge clk_in); #1;
  endtask

  typedef struct {
    logic [31:0] a; logic [7:0] d; logic wr, txr, rxv; logic [7:0] rxd;
    logic e_rdy, e_txv; logic [7:0] e_txd; logic cd; logic [7:0] e_din;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input logic [31:0] a, input logic [7:0] d, input logic wr, txr, rxv,
                              input logic [7:0] rxd, input logic er, ev, input logic [7:0] etx,
                              input logic cd, input logic [7:0] edin);
    vec_t v;
    v.a = a; v.d = d; v.wr = wr; v.txr = txr; v.rxv = rxv; v.rxd = rxd;
    v.e_rdy = er; v.e_txv = ev; v.e_txd = etx; v.cd = cd; v.e_din = edin;
    return v;
  endfunction

  initial begin
    logic [31:0] ca [7];
    logic [7:0]  ce [6];
    logic [31:0] ra;
    logic [7:0]  rd;
    logic        rw;
    int          sel;
    for (int i = 0; i < 131072; i++) begin mem[i] = 8'h00; mm[i] = 8'h00; end

    tbl.push_back(mk(32'h0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 8'h00));
    tbl.push_back(mk(32'h100, 8'h5A, 1, 0, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00));
    tbl.push_back(mk(32'h100, 8'h00, 0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00));
    tbl.push_back(mk(32'h0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 8'h00, 1, 8'h5A));
    tbl.push_back(mk(32'h30000, 8'h48, 1, 1, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00));
    tbl.push_back(mk(32'h30000, 8'h69, 1, 1, 0, 8'h00, 1, 1, 8'h48, 0, 8'h00));
    tbl.push_back(mk(32'h30000, 8'h00, 1, 1, 0, 8'h00, 1, 1, 8'h69, 0, 8'h00));
    tbl.push_back(mk(32'h0, 8'h00, 0, 1, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00));
    for (int i = 0; i < 16; i++)
      tbl.push_back(mk(32'h30000, 8'h41, 1, 0, 0, 8'h00, 1, i > 0, 8'h41, 0, 8'h00));
    tbl.push_back(mk(32'h30000, 8'h41, 1, 0, 0, 8'h00, 0, 1, 8'h41, 0, 8'h00));
    tbl.push_back(mk(32'h30000, 8'h41, 1, 1, 0, 8'h00, 0, 1, 8'h41, 0, 8'h00));
    tbl.push_back(mk(32'h30000, 8'h41, 1, 0, 0, 8'h00, 1, 1, 8'h41, 0, 8'h00));
    for (int i = 0; i < 16; i++)
      tbl.push_back(mk(32'h0, 8'h00, 0, 1, 0, 8'h00, 1, 1, 8'h41, 0, 8'h00));
    tbl.push_back(mk(32'h0, 8'h00, 0, 1, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00));
    tbl.push_back(mk(32'h0, 8'h00, 0, 0, 1, 8'h31, 1, 0, 8'h00, 0, 8'h00));
    tbl.push_back(mk(32'h0, 8'h00, 0, 0, 1, 8'h32, 1, 0, 8'h00, 0, 8'h00));
    tbl.push_back(mk(32'h30000, 8'h00, 0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00));
    tbl.push_back(mk(32'h30000, 8'h00, 0, 0, 0, 8'h00, 1, 0, 8'h00, 1, 8'h31));
    tbl.push_back(mk(32'h30000, 8'h00, 0, 0, 0, 8'h00, 1, 0, 8'h00, 1, 8'h32));
    tbl.push_back(mk(32'h0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 8'h00, 1, 8'h00));

    // reset with a RAM write request pending: nothing may be written
    step(0, 32'h100, 8'hEE, 1, 0, 0, 8'h00);
    step(0, 32'h100, 8'hEE, 1, 0, 0, 8'h00);
    foreach (tbl[i]) begin
      step(1, tbl[i].a, tbl[i].d, tbl[i].wr, tbl[i].txr, tbl[i].rxv, tbl[i].rxd);
      chk($sformatf("tbl%0d_rdy", i), s_rdy, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_txv", i), s_txv, tbl[i].e_txv);
      if (tbl[i].e_txv) chk($sformatf("tbl%0d_txd", i), s_txd, tbl[i].e_txd);
      if (tbl[i].cd) chk($sformatf("tbl%0d_din", i), s_din, tbl[i].e_din);
    end

    // counter near wrap: one snapshot serves all four bytes, the next one shows the wrap
    force dut.cnt_q = 32'hFFFF_FFFD;
    #1 release dut.cnt_q;
    mcnt = 32'hFFFF_FFFD;
    ca = '{32'h30004, 32'h30005, 32'h30006, 32'h30007, 32'h30004, 32'h30007, 32'h0};
    ce = '{8'hFD, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h00};
    for (int i = 0; i < 7; i++) begin
      step(1, ca[i], 8'h00, 0, 0, 0, 8'h00);
      if (i > 0) chk($sformatf("snap%0d", i - 1), s_din, ce[i-1]);
    end

    // halt: 0x00 queued behind 0x55, CPU frozen, TX keeps draining, async reset clears it
    step(1, 32'h30000, 8'h55, 1, 0, 1, 8'h77); chk("h0_rdy", s_rdy, 1);
    step(1, 32'h30004, 8'hAB, 1, 0, 0, 8'h00); chk("h1_rdy", s_rdy, 1); chk("h1_txd", s_txd, 8'h55);
    step(1, 32'h0, 8'h00, 0, 0, 0, 8'h00); chk("h2_rdy", s_rdy, 0); chk("h2_halt", s_halt, 1);
    step(1, 32'h0, 8'h00, 0, 1, 0, 8'h00); chk("h3_rdy", s_rdy, 0); chk("h3_txd", s_txd, 8'h55);
    step(1, 32'h0, 8'h00, 0, 0, 0, 8'h00); chk("h4_txv", s_txv, 1); chk("h4_txd", s_txd, 8'h00);
    chk("h4_halt", s_halt, 1);
    #2 rst_in = 1'b0;
    #1;
    chk("async_halt", halt, 0);
    chk("async_txv", tx_valid, 0);
    chk("async_rdy", cpu_rdy, 0);
    chk("async_rxr", rx_ready, 0);
    step(0, 32'h0, 8'h00, 0, 0, 0, 8'h00);
    step(0, 32'h0, 8'h00, 0, 0, 0, 8'h00);

    // random traffic; the CPU holds its request while not ready
    ra = '0; rd = '0; rw = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if (mr_last) begin
        sel = $urandom_range(0, 9);
        ra = $urandom;
        rw = $urandom_range(0, 1) == 1;
        rd = 8'($urandom);
        if (sel < 4) begin
          ra[17:16] = 2'($urandom_range(0, 2));
          ra[15:0] = 16'($urandom_range(0, 63));
        end else if (sel < 7) ra[17:0] = 18'h30000;
        else if (sel == 7) begin ra[17:0] = 18'h30004 + 18'($urandom_range(0, 3)); rw = 1'b0; end
        else if (sel == 8) begin
          ra[17:16] = 2'b11;
          if (ra[17:0] == 18'h30004) rw = 1'b0;
        end else begin ra[17:0] = 18'h30000; rw = 1'b0; end
        if (rw && rd == 8'h00 && $urandom_range(0, 3) != 0) rd = 8'h5C;
      end
      step(1, ra, rd, rw, (n < 2000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
           $urandom_range(0, 1) == 1, 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
